reg_alu_ctrl: RTL and testbench
===============================

REG_ALU_CTRL -- requirements
Module: reg_alu_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port instr, input, 16 bits: instruction word, sampled when accepted.
REQ-004 SHALL have port instrValid, input, 1 bit: instr is valid.
REQ-005 SHALL have port instrReady, output, 1 bit: block can accept an instruction.
REQ-006 SHALL have ports aluA and aluB, outputs, 16 bits each: ALU operands a and b.
REQ-007 SHALL have ports aluOpCode and aluOpExt, outputs, 4 bits each: ALU opCode and opExt.
REQ-008 SHALL have port aluResult, input, 16 bits: ALU combinational result.
REQ-009 SHALL have port aluPSR, input, 8 bits, format 000CLFZN: ALU combinational flags.
REQ-010 SHALL have port psr, output, 8 bits: the latched processor status register.
REQ-011 SHALL have port busy, output, 1 bit: an instruction is in flight.
REQ-012 SHALL have ports dbgSel, input, 4 bits, and dbgData, output, 16 bits: combinational read of register dbgSel.

Function
REQ-013 SHALL hold 16 general registers R0..R15 of 16 bits each; R0 is an ordinary, writable register.
REQ-014 SHALL decode register form when instr[15:12]=0000: Rdest=[11:8], opExt=[7:4], Rsrc=[3:0].
REQ-015 SHALL decode immediate form when instr[15:12]!=0000: Rdest=[11:8], imm=[7:0], with ext=instr[15:12].
REQ-016 SHALL sign-extend imm for ext 0101 (ADDI), 1001 (SUBI) and 1011 (CMPI), and zero-extend imm for all other ext values.
REQ-017 SHALL drive aluOpCode=0000 in all cases, and aluOpExt=instr[7:4] (register form) or instr[15:12] (immediate form).
REQ-018 SHALL drive aluA=R[Rdest], and aluB=R[Rsrc] (register form) or the extended imm (immediate form).
REQ-019 SHALL implement FSM states IDLE, DECODE, EXECUTE and WRITEBACK.
REQ-020 IDLE: instrReady=1; on instrValid=1, capture instr and go to DECODE; otherwise stay in IDLE.
REQ-021 DECODE: read operands into operand registers; go to EXECUTE.
REQ-022 EXECUTE: drive the ALU outputs from the operand registers; capture aluResult and aluPSR; go to WRITEBACK.
REQ-023 WRITEBACK: write the captured result to Rdest unless the op is CMP or CMPI (ext 1011); go to IDLE.
REQ-024 SHALL update psr from the captured flags only for ext 0101, 1001 and 1011; all other ops leave psr unchanged.
REQ-025 SHALL treat any opExt or ext value outside {0001,0010,0011,0101,1001,1011,1101} as a NOP: no register write, no psr change, same state sequence.
REQ-026 SHALL make the new Rdest value and psr visible 4 cycles after the accepting edge; the next instruction is accepted in IDLE (throughput 1 instruction per 4 cycles).
REQ-027 busy SHALL be high in DECODE, EXECUTE and WRITEBACK, and instrReady SHALL be high only in IDLE.
REQ-028 When Rdest equals Rsrc, the pre-write value SHALL be used for both operands.
REQ-029 A back-to-back dependent instruction SHALL see the value written by the previous WRITEBACK (no hazard, because operands are read in DECODE after the write).
REQ-030 aluA, aluB, aluOpCode and aluOpExt SHALL be 0 outside EXECUTE.

Reset
REQ-031 On reset=1 at a clock edge: state=IDLE, all R0..R15=0, psr=0, operand and capture registers=0.
REQ-032 After reset, instrReady=1, busy=0 and all ALU outputs=0.
REQ-033 Reset asserted during any non-IDLE state SHALL abort the instruction with no register write and no psr update.
REQ-034 Reset SHALL take priority over instrValid in the same cycle.

Structure
REQ-035 Opcode/ext constants (ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, MOV 1101), state encodings and PSR bit positions SHALL reside in a shared defines file used by the ALU and this block.
REQ-036 The register array SHALL be a sub-module named regfile, with 2 combinational read ports plus the dbg read port, 1 synchronous write port, and synchronous reset.

Verification
REQ-037 Reset, then register-form ADD with R1=1, R2=2 (instr 0x0152) -> R1=3 and psr=0x00 at 4 cycles after acceptance.
REQ-038 ADDI with R3=0x7FFF, instr 0x5301 -> R3=0x8000 and psr=0x04 (F flag).
REQ-039 CMP with R4=3, R5=4 (instr 0x04B5) -> R4 unchanged and psr=0x08 (L flag); then AND (instr 0x0415) -> psr still 0x08.
REQ-040 SUBI with R6=3, instr 0x96FF (imm -1) -> R6=4; with instrValid held high, the second instruction is accepted exactly 4 cycles after the first.
REQ-041 Reset asserted in EXECUTE of ADD R7 -> R7=0, psr=0, state IDLE on the next cycle, and no later write.
REQ-042 Undefined opExt 0111 (instr 0x0871) -> R8 and psr unchanged, busy high for 3 cycles.

Source files
------------

// File: rtl/reg_alu_ctrl_pkg.sv
// Shared ALU opcode/ext constants, PSR bit positions, controller states and
// the instruction decoder used by the register/ALU controller.
package reg_alu_ctrl_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_COUNT = 16;

    localparam logic [3:0] ALU_OPCODE = 4'b0000;

    localparam logic [3:0] EXT_REG = 4'b0000;
    localparam logic [3:0] EXT_AND = 4'b0001;
    localparam logic [3:0] EXT_OR  = 4'b0010;
    localparam logic [3:0] EXT_XOR = 4'b0011;
    localparam logic [3:0] EXT_ADD = 4'b0101;
    localparam logic [3:0] EXT_SUB = 4'b1001;
    localparam logic [3:0] EXT_CMP = 4'b1011;
    localparam logic [3:0] EXT_MOV = 4'b1101;

    // PSR format 000CLFZN
    localparam int PSR_N = 0;
    localparam int PSR_Z = 1;
    localparam int PSR_F = 2;
    localparam int PSR_L = 3;
    localparam int PSR_C = 4;
    localparam logic [7:0] PSR_MASK = 8'((1 << PSR_C) | (1 << PSR_L) | (1 << PSR_F)
                                        | (1 << PSR_Z) | (1 << PSR_N));

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DECODE    = 2'd1,
        S_EXECUTE   = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    typedef struct packed {
        logic        imm_form;
        logic [3:0]  ext;
        logic [3:0]  rdest;
        logic [3:0]  rsrc;
        logic [15:0] imm;
    } decode_t;

    function automatic logic is_defined(input logic [3:0] ext);
        return ext inside {EXT_AND, EXT_OR, EXT_XOR, EXT_ADD, EXT_SUB, EXT_CMP, EXT_MOV};
    endfunction

    function automatic logic writes_reg(input logic [3:0] ext);
        return is_defined(ext) && (ext != EXT_CMP);
    endfunction

    function automatic logic sets_psr(input logic [3:0] ext);
        return ext inside {EXT_ADD, EXT_SUB, EXT_CMP};
    endfunction

    function automatic decode_t decode(input logic [15:0] word);
        decode_t d;
        d.imm_form = (word[15:12] != EXT_REG);
        d.ext      = d.imm_form ? word[15:12] : word[7:4];
        d.rdest    = word[11:8];
        d.rsrc     = word[3:0];
        // Arithmetic immediates are signed; logical/move immediates are not.
        if (sets_psr(word[15:12]))
            d.imm = {{8{word[7]}}, word[7:0]};
        else
            d.imm = {8'h00, word[7:0]};
        return d;
    endfunction

endpackage

// File: rtl/reg_alu_ctrl_regfile.sv
// Sixteen 16-bit general registers: two operand read ports, one debug read
// port, one synchronous write port, synchronous active-high clear.
module regfile
    import reg_alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        rd_a_sel,
    output logic [DATA_W-1:0] rd_a_data,
    input  logic [3:0]        rd_b_sel,
    output logic [DATA_W-1:0] rd_b_data,
    input  logic [3:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wr_en,
    input  logic [3:0]        wr_sel,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs [REG_COUNT];

    // NOTE: the whole array is cleared on reset, so it maps to flops rather
    // than a RAM macro; at 16x16 that is the intended implementation.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++)
                regs[i] <= '0;
        end else if (wr_en) begin
            regs[wr_sel] <= wr_data;
        end
    end

    assign rd_a_data = regs[rd_a_sel];
    assign rd_b_data = regs[rd_b_sel];
    assign dbg_data  = regs[dbg_sel];

endmodule

// File: rtl/reg_alu_ctrl.sv
// Four-state controller sequencing one instruction through an external
// combinational ALU: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
module reg_alu_ctrl
    import reg_alu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instrValid,
    output logic        instrReady,
    output logic [15:0] aluA,
    output logic [15:0] aluB,
    output logic [3:0]  aluOpCode,
    output logic [3:0]  aluOpExt,
    input  logic [15:0] aluResult,
    input  logic [7:0]  aluPSR,
    output logic [7:0]  psr,
    output logic        busy,
    input  logic [3:0]  dbgSel,
    output logic [15:0] dbgData
);

    state_t      state, state_next;
    logic [15:0] instr_q;
    logic [15:0] op_a, op_b;
    logic [15:0] result_q;
    logic [7:0]  flags_q;
    logic [7:0]  psr_q;
    logic [15:0] rd_a, rd_b;
    logic        wr_en;
    decode_t     dec;

    assign dec   = decode(instr_q);
    assign wr_en = (state == S_WRITEBACK) && writes_reg(dec.ext);

    regfile u_regfile (
        .clk       (clk),
        .reset     (reset),
        .rd_a_sel  (dec.rdest),
        .rd_a_data (rd_a),
        .rd_b_sel  (dec.rsrc),
        .rd_b_data (rd_b),
        .dbg_sel   (dbgSel),
        .dbg_data  (dbgData),
        .wr_en     (wr_en),
        .wr_sel    (dec.rdest),
        .wr_data   (result_q)
    );

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            instr_q  <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            psr_q    <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE:      if (instrValid) instr_q <= instr;
                S_DECODE: begin
                    op_a <= rd_a;
                    op_b <= dec.imm_form ? dec.imm : rd_b;
                end
                S_EXECUTE: begin
                    result_q <= aluResult;
                    flags_q  <= aluPSR;
                end
                S_WRITEBACK: if (sets_psr(dec.ext)) psr_q <= flags_q & PSR_MASK;
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        instrReady = 1'b0;
        busy       = 1'b0;
        aluA       = '0;
        aluB       = '0;
        aluOpExt   = '0;
        case (state)
            S_IDLE: begin
                instrReady = 1'b1;
                if (instrValid) state_next = S_DECODE;
            end
            S_DECODE: begin
                busy       = 1'b1;
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                busy       = 1'b1;
                aluA       = op_a;
                aluB       = op_b;
                aluOpExt   = dec.ext;
                state_next = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                busy       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign aluOpCode = ALU_OPCODE;
    assign psr       = psr_q;

endmodule

// File: tb/tb_reg_alu_ctrl.sv
// Directed bench for reg_alu_ctrl with a behavioural ALU closing the loop.
// ALU flags: ADD/SUB set C (carry/borrow) and F (overflow); CMP sets Z (a==b), L (a<b unsigned), N (a>b signed).
module tb_reg_alu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instrValid;
    logic        instrReady;
    logic [15:0] aluA, aluB;
    logic [3:0]  aluOpCode, aluOpExt;
    logic [15:0] aluResult;
    logic [7:0]  aluPSR;
    logic [7:0]  psr;
    logic        busy;
    logic [3:0]  dbgSel;
    logic [15:0] dbgData;

    int errors = 0;
    int checks = 0;

    reg_alu_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .instrValid (instrValid),
        .instrReady (instrReady),
        .aluA       (aluA),
        .aluB       (aluB),
        .aluOpCode  (aluOpCode),
        .aluOpExt   (aluOpExt),
        .aluResult  (aluResult),
        .aluPSR     (aluPSR),
        .psr        (psr),
        .busy       (busy),
        .dbgSel     (dbgSel),
        .dbgData    (dbgData)
    );

    always #10 clk = ~clk;

    function automatic logic [23:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] ext);
        logic [16:0] s;
        logic [15:0] r;
        logic [7:0]  f;
        r = '0;
        f = '0;
        case (ext)
            4'b0001: r = a & b;
            4'b0010: r = a | b;
            4'b0011: r = a ^ b;
            4'b1101: r = b;
            4'b0101: begin
                s    = {1'b0, a} + {1'b0, b};
                r    = s[15:0];
                f[4] = s[16];
                f[2] = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'b1001: begin
                r    = a - b;
                f[4] = (a < b);
                f[2] = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'b1011: begin
                r    = a - b;
                f[3] = (a < b);
                f[1] = (a == b);
                f[0] = ($signed(a) > $signed(b));
            end
            default: ;
        endcase
        return {f, r};
    endfunction

    always_comb {aluPSR, aluResult} = alu_model(aluA, aluB, aluOpExt);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] sel, input logic [15:0] exp);
        dbgSel = sel;
        #1;
        check(tag, dbgData, exp);
    endtask

    // Waits (bounded) for IDLE, presents one instruction for one edge, then
    // runs the three remaining cycles so the controller is back in IDLE.
    task automatic issue(input logic [15:0] word);
        int waited = 0;
        while (!instrReady && waited < 10) begin
            tick();
            waited++;
        end
        check("ready_before_issue", 16'(instrReady), 16'h0001);
        instr      = word;
        instrValid = 1'b1;
        tick();
        instrValid = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        reset      = 1'b1;
        instr      = 16'hD1AA;
        instrValid = 1'b1;
        dbgSel     = 4'd0;

        // Reset wins over a valid instruction in the same cycle.
        tick();
        tick();
        reset      = 1'b0;
        instrValid = 1'b0;
        check("rst_ready", 16'(instrReady), 16'h0001);
        check("rst_busy", 16'(busy), 16'h0000);
        check("rst_aluA", aluA, 16'h0000);
        check("rst_aluB", aluB, 16'h0000);
        check("rst_opext", 16'(aluOpExt), 16'h0000);
        check("rst_psr", 16'(psr), 16'h0000);
        check_reg("rst_r1", 4'd1, 16'h0000);

        // ADD R1,R2 with per-state output checks.
        issue(16'hD101);
        issue(16'hD202);
        instr      = 16'h0152;
        instrValid = 1'b1;
        tick();
        instrValid = 1'b0;
        check("dec_busy", 16'(busy), 16'h0001);
        check("dec_ready", 16'(instrReady), 16'h0000);
        check("dec_aluA", aluA, 16'h0000);
        tick();
        check("exe_aluA", aluA, 16'h0001);
        check("exe_aluB", aluB, 16'h0002);
        check("exe_opext", 16'(aluOpExt), 16'h0005);
        check("exe_opcode", 16'(aluOpCode), 16'h0000);
        tick();
        check("wb_busy", 16'(busy), 16'h0001);
        check("wb_aluB", aluB, 16'h0000);
        tick();
        check("add_ready", 16'(instrReady), 16'h0001);
        check_reg("add_r1", 4'd1, 16'h0003);
        check_reg("add_r2", 4'd2, 16'h0002);
        check("add_psr", 16'(psr), 16'h0000);

        // Build R3=0x7FFF with MOVI, self-doubling ADD R3,R3 and ORI.
        issue(16'hD37F);
        for (int i = 0; i < 8; i++) issue(16'h0353);
        issue(16'h23FF);
        check_reg("build_r3", 4'd3, 16'h7FFF);
        issue(16'h5301);
        check_reg("addi_r3", 4'd3, 16'h8000);
        check("addi_psr", 16'(psr), 16'h0004);

        // CMP leaves Rdest alone; AND leaves psr alone.
        issue(16'hD403);
        issue(16'hD504);
        issue(16'h04B5);
        check_reg("cmp_r4", 4'd4, 16'h0003);
        check("cmp_psr", 16'(psr), 16'h0008);
        issue(16'h0415);
        check_reg("and_r4", 4'd4, 16'h0000);
        check("and_psr", 16'(psr), 16'h0008);

        // SUBI with instrValid held: next (dependent) ADDI accepted 4 cycles later.
        issue(16'hD603);
        instr      = 16'h96FF;
        instrValid = 1'b1;
        tick();
        check("subi_busy", 16'(busy), 16'h0001);
        instr = 16'h5601;
        tick();
        check("hold_ready1", 16'(instrReady), 16'h0000);
        tick();
        check("hold_ready2", 16'(instrReady), 16'h0000);
        tick();
        check("hold_ready3", 16'(instrReady), 16'h0001);
        check_reg("subi_r6", 4'd6, 16'h0004);
        check("subi_psr", 16'(psr), 16'h0010);
        tick();
        instrValid = 1'b0;
        check("second_accept", 16'(busy), 16'h0001);
        tick();
        tick();
        tick();
        check_reg("dep_r6", 4'd6, 16'h0005);
        check("dep_psr", 16'(psr), 16'h0000);

        // MOVI zero-extends; CMPI sets psr; undefined ops are NOPs.
        issue(16'hD8F0);
        check_reg("movi_zext", 4'd8, 16'h00F0);
        issue(16'hD855);
        issue(16'hB856);
        check("cmpi_psr", 16'(psr), 16'h0008);
        instr      = 16'h0871;
        instrValid = 1'b1;
        tick();
        instrValid = 1'b0;
        check("nop_busy1", 16'(busy), 16'h0001);
        tick();
        check("nop_busy2", 16'(busy), 16'h0001);
        tick();
        check("nop_busy3", 16'(busy), 16'h0001);
        tick();
        check("nop_idle", 16'(busy), 16'h0000);
        check_reg("nop_r8", 4'd8, 16'h0055);
        check("nop_psr", 16'(psr), 16'h0008);
        issue(16'h4812);
        check_reg("nopi_r8", 4'd8, 16'h0055);
        check("nopi_psr", 16'(psr), 16'h0008);

        // Reset during EXECUTE of ADD R7,R7 aborts the write.
        issue(16'hD709);
        instr      = 16'h0757;
        instrValid = 1'b1;
        tick();
        instrValid = 1'b0;
        tick();
        check("abort_exe_aluA", aluA, 16'h0009);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", 16'(instrReady), 16'h0001);
        check("abort_busy", 16'(busy), 16'h0000);
        check("abort_psr", 16'(psr), 16'h0000);
        check_reg("abort_r7", 4'd7, 16'h0000);
        check_reg("abort_r1", 4'd1, 16'h0000);
        tick();
        tick();
        tick();
        tick();
        check_reg("abort_late_r7", 4'd7, 16'h0000);
        check("abort_late_busy", 16'(busy), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
